// File: rtl/slice_merge_pkg.sv
// Shared encodings and constants for the slice-merge register.
package slice_merge_pkg;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'b00,
      CNT_INC  = 2'b01,
      CNT_DEC  = 2'b10,
      CNT_ROL  = 2'b11
   } cnt_mode_e;

   localparam int WR_COUNT_W = 16;
   localparam logic [WR_COUNT_W-1:0] WR_COUNT_MAX = '1;

endpackage

// File: rtl/slice_merge_reg_mask_gen.sv
// One write channel: turns base/dir/data into a register-wide bit mask,
// the data aligned under that mask, and a flag for any bit that falls off either end.
module slice_mask_gen #(
   parameter int WIDTH  = 32,
   parameter int SLICEW = 4,
   parameter int CTRLW  = 5
) (
   input  logic [CTRLW-1:0]  base,
   input  logic              dir,
   input  logic [SLICEW-1:0] data,
   output logic [WIDTH-1:0]  mask,
   output logic [WIDTH-1:0]  aligned,
   output logic              oob
);

   localparam logic [WIDTH-1:0] ONES = WIDTH'({SLICEW{1'b1}});

   logic [WIDTH-1:0] data_ext;
   int               lo;

   assign data_ext = WIDTH'(data);

   // Both directions reduce to a slice starting at bit lo; lo may be negative
   // (descending underflow) and shifting past either end drops the bits.
   always_comb begin
      lo      = dir ? int'(base) - (SLICEW - 1) : int'(base);
      mask    = '0;
      aligned = '0;
      if (lo >= 0) begin
         mask    = ONES << lo;
         aligned = data_ext << lo;
      end else begin
         mask    = ONES >> (-lo);
         aligned = data_ext >> (-lo);
      end
      oob = (lo < 0) || (lo + SLICEW > WIDTH);
   end

endmodule

// File: rtl/slice_merge_reg.sv
// Counting data register with NCH slice-write channels overlaid on the count result;
// the highest-numbered channel wins overlapping bits.
module slice_merge_reg
   import slice_merge_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter int               SLICEW    = 4,
   parameter int               NCH       = 2,
   parameter int               CTRLW     = $clog2(WIDTH),
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              cnt_mode,
   input  logic                    freeze,
   input  logic [NCH-1:0]          wr_valid,
   output logic [NCH-1:0]          wr_ready,
   input  logic [NCH-1:0]          wr_dir,
   input  logic [NCH*CTRLW-1:0]    wr_base,
   input  logic [NCH*SLICEW-1:0]   wr_data,
   output logic [WIDTH-1:0]        dout,
   output logic [WR_COUNT_W-1:0]   wr_count,
   output logic                    oob_err,
   output logic [NCH-1:0]          oob_chan
);

   logic [WIDTH-1:0]      mask    [NCH];
   logic [WIDTH-1:0]      aligned [NCH];
   logic [WIDTH-1:0]      stage   [NCH+1];
   logic [NCH-1:0]        oob;
   logic [NCH-1:0]        accept;
   logic [NCH-1:0]        oob_hit;
   logic [WIDTH-1:0]      counted;
   logic [WR_COUNT_W:0]   count_sum;
   logic [WR_COUNT_W-1:0] count_next;

   assign wr_ready = {NCH{~freeze}};
   assign accept   = wr_valid & wr_ready;
   assign oob_hit  = accept & oob;

   always_comb begin
      case (cnt_mode_e'(cnt_mode))
         CNT_INC: counted = dout + WIDTH'(1);
         CNT_DEC: counted = dout - WIDTH'(1);
         CNT_ROL: counted = {dout[WIDTH-2:0], dout[WIDTH-1]};
         default: counted = dout;
      endcase
   end

   // Overlay chain: later stages (higher channels) overwrite earlier ones bit by bit.
   assign stage[0] = counted;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
         slice_mask_gen #(
            .WIDTH  (WIDTH),
            .SLICEW (SLICEW),
            .CTRLW  (CTRLW)
         ) u_mask_gen (
            .base    (wr_base[gi*CTRLW +: CTRLW]),
            .dir     (wr_dir[gi]),
            .data    (wr_data[gi*SLICEW +: SLICEW]),
            .mask    (mask[gi]),
            .aligned (aligned[gi]),
            .oob     (oob[gi])
         );

         assign stage[gi+1] = accept[gi] ? ((stage[gi] & ~mask[gi]) | (aligned[gi] & mask[gi]))
                                         : stage[gi];
      end
   endgenerate

   always_comb begin
      count_sum  = {1'b0, wr_count} + (WR_COUNT_W+1)'($countones(accept));
      count_next = count_sum[WR_COUNT_W] ? WR_COUNT_MAX : count_sum[WR_COUNT_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout     <= RESET_VAL;
         wr_count <= '0;
         oob_err  <= 1'b0;
         oob_chan <= '0;
      end else if (!freeze) begin
         dout     <= stage[NCH];
         wr_count <= count_next;
         oob_chan <= oob_chan | oob_hit;
         oob_err  <= oob_err | (|oob_hit);
      end
   end

endmodule

// File: tb/tb_slice_merge_reg.sv
// Directed bench for slice_merge_reg: per-cycle comparison against a bit-level
// behavioural model plus hand-computed checkpoints.
module tb_slice_merge_reg;

   localparam int          WIDTH  = 32;
   localparam int          SLICEW = 4;
   localparam int          NCH    = 2;
   localparam int          CTRLW  = 5;
   localparam logic [31:0] RV     = 32'h0;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [1:0]          cnt_mode = 2'b00;
   logic                freeze = 1'b0;
   logic [NCH-1:0]      wr_valid = '0;
   logic [NCH-1:0]      wr_ready;
   logic [NCH-1:0]      wr_dir = '0;
   logic [NCH*CTRLW-1:0]  wr_base = '0;
   logic [NCH*SLICEW-1:0] wr_data = '0;
   logic [WIDTH-1:0]    dout;
   logic [15:0]         wr_count;
   logic                oob_err;
   logic [NCH-1:0]      oob_chan;

   int n_cmp = 0;
   int n_bad = 0;

   slice_merge_reg #(
      .WIDTH(WIDTH), .SLICEW(SLICEW), .NCH(NCH), .CTRLW(CTRLW), .RESET_VAL(RV)
   ) dut (
      .clk(clk), .rst(rst), .cnt_mode(cnt_mode), .freeze(freeze),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dir(wr_dir),
      .wr_base(wr_base), .wr_data(wr_data), .dout(dout),
      .wr_count(wr_count), .oob_err(oob_err), .oob_chan(oob_chan)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: walk each slice bit to its absolute position, write it if it lands in range.
   logic [31:0] m_dout = RV;
   int          m_count = 0;
   logic        m_err = 1'b0;
   logic [1:0]  m_chan = '0;

   always @(posedge clk or posedge rst) begin
      logic [31:0] nxt;
      logic [3:0]  d;
      logic [1:0]  chan;
      int          cnt, b, pos;
      if (rst) begin
         m_dout  <= RV;
         m_count <= 0;
         m_err   <= 1'b0;
         m_chan  <= '0;
      end else if (!freeze) begin
         case (cnt_mode)
            2'd1:    nxt = m_dout + 32'd1;
            2'd2:    nxt = m_dout - 32'd1;
            2'd3:    nxt = (m_dout << 1) | (m_dout >> 31);
            default: nxt = m_dout;
         endcase
         chan = m_chan;
         cnt  = m_count;
         for (int c = 0; c < NCH; c++) begin
            if (wr_valid[c]) begin
               b = int'(wr_base[c*CTRLW +: CTRLW]);
               d = wr_data[c*SLICEW +: SLICEW];
               for (int k = 0; k < SLICEW; k++) begin
                  pos = wr_dir[c] ? b - k : b + k;
                  if (pos >= 0 && pos < WIDTH)
                     nxt[pos] = wr_dir[c] ? d[SLICEW-1-k] : d[k];
                  else
                     chan[c] = 1'b1;
               end
               cnt = (cnt + 1 > 65535) ? 65535 : cnt + 1;
            end
         end
         m_dout  <= nxt;
         m_count <= cnt;
         m_chan  <= chan;
         m_err   <= |chan;
      end
   end

   always @(negedge clk) begin
      check("model_dout", dout, m_dout);
      check("model_count", wr_count, m_count);
      check("model_oob_err", oob_err, m_err);
      check("model_oob_chan", oob_chan, m_chan);
      check("model_ready", wr_ready, {NCH{~freeze}});
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wr(input logic [1:0] v,
                     input logic [4:0] b0, input logic dr0, input logic [3:0] d0,
                     input logic [4:0] b1, input logic dr1, input logic [3:0] d1);
      wr_valid = v;
      wr_base  = {b1, b0};
      wr_dir   = {dr1, dr0};
      wr_data  = {d1, d0};
   endtask

   initial begin
      tick(2);
      check("reset_dout", dout, RV);
      check("reset_count", wr_count, 0);
      check("reset_flags", {oob_err, oob_chan}, 3'b000);
      rst = 1'b0;

      cnt_mode = 2'b01;
      tick(5);
      check("inc5_dout", dout, 32'h5);
      check("inc5_count", wr_count, 0);

      cnt_mode = 2'b10;
      tick(5);
      check("dec_back_to_zero", dout, 32'h0);

      cnt_mode = 2'b00;
      wr(2'b11, 5'd8, 1'b0, 4'hA, 5'd11, 1'b1, 4'h5);
      tick(1);
      check("overlap_dout", dout, 32'h0000_0500);
      check("overlap_count", wr_count, 2);
      check("overlap_no_oob", oob_err, 1'b0);

      wr(2'b01, 5'd8, 1'b0, 4'h0, 5'd0, 1'b0, 4'h0);
      tick(1);
      check("clear_dout", dout, 32'h0);

      wr(2'b01, 5'd30, 1'b0, 4'hF, 5'd0, 1'b0, 4'h0);
      tick(1);
      check("asc_oob_dout", dout, 32'hC000_0000);
      check("asc_oob_chan", {oob_err, oob_chan}, 3'b101);
      wr(2'b00, 5'd0, 1'b0, 4'h0, 5'd0, 1'b0, 4'h0);
      tick(10);
      check("oob_sticky", {oob_err, oob_chan}, 3'b101);
      check("oob_sticky_count", wr_count, 4);

      wr(2'b10, 5'd0, 1'b0, 4'h0, 5'd1, 1'b1, 4'hF);
      tick(1);
      check("desc_oob_dout", dout, 32'hC000_0003);
      check("desc_oob_chan", oob_chan, 2'b11);

      cnt_mode = 2'b01;
      wr(2'b01, 5'd0, 1'b0, 4'h0, 5'd0, 1'b0, 4'h0);
      tick(1);
      check("write_over_count", dout, 32'hC000_0000);

      cnt_mode = 2'b00;
      wr(2'b11, 5'd28, 1'b0, 4'h8, 5'd0, 1'b0, 4'h1);
      tick(1);
      check("setup_rol", dout, 32'h8000_0001);
      wr(2'b00, 5'd0, 1'b0, 4'h0, 5'd0, 1'b0, 4'h0);
      cnt_mode = 2'b11;
      tick(1);
      check("rol_wrap", dout, 32'h0000_0003);

      cnt_mode = 2'b00;
      wr(2'b01, 5'd0, 1'b0, 4'h0, 5'd0, 1'b0, 4'h0);
      tick(1);
      wr(2'b00, 5'd0, 1'b0, 4'h0, 5'd0, 1'b0, 4'h0);
      cnt_mode = 2'b10;
      tick(1);
      check("dec_underflow", dout, 32'hFFFF_FFFF);
      check("count_before_freeze", wr_count, 9);

      freeze   = 1'b1;
      cnt_mode = 2'b01;
      wr(2'b11, 5'd0, 1'b0, 4'h5, 5'd4, 1'b0, 4'h6);
      #1;
      check("freeze_ready", wr_ready, 2'b00);
      tick(3);
      check("freeze_dout", dout, 32'hFFFF_FFFF);
      check("freeze_count", wr_count, 9);
      freeze = 1'b0;
      tick(1);
      check("resume_dout", dout, 32'h0000_0065);
      check("resume_count", wr_count, 11);

      cnt_mode = 2'b00;
      tick(32770);
      check("count_saturated", wr_count, 16'hFFFF);

      cnt_mode = 2'b01;
      tick(1);
      #1 rst = 1'b1;
      #1;
      check("async_rst_dout", dout, RV);
      check("async_rst_count", wr_count, 0);
      check("async_rst_flags", {oob_err, oob_chan}, 3'b000);
      tick(1);
      check("rst_edge_discard", dout, RV);
      rst = 1'b0;
      tick(1);
      check("post_rst_dout", dout, 32'h0000_0065);
      check("post_rst_count", wr_count, 2);

      wr(2'b00, 5'd0, 1'b0, 4'h0, 5'd0, 1'b0, 4'h0);
      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
